regfile_burst_reader: RTL and testbench
=======================================

// Module: regfile_burst_reader
// PURPOSE
//  Read-side sequencer for the 16x32 register bank (reg32_ad).
//  - On a start command, reads a contiguous run of lines: it drives read_en and read_line.
//  - It captures data_out_bus, tags each word with its line index and streams the words out.
//  - Output uses a valid/ready port with an internal FIFO that absorbs back-pressure.
//  - Sits between the register bank and any consumer: debug dump, DMA, checksum unit.
// PARAMETERS
//  DW      32  data width; matches data_out_bus
//  AW      4   line index width; 16 lines
//  RD_LAT  1   register bank read latency in cycles; legal range 1..3
//  DEPTH   4   output FIFO entries; power of 2, >= RD_LAT+1
// PORTS
//  clk         in   1     rising-edge clock
//  reset_n     in   1     asynchronous active-low reset
//  start       in   1     begin burst; sampled only in IDLE
//  start_line  in   AW    first line of burst
//  count       in   AW+1  number of lines, 0..16
//  busy        out  1     high from accepted start until done
//  done        out  1     1-cycle pulse when the last word is popped, or on an empty burst
//  read_en     out  1     registered read strobe to the register bank
//  read_line   out  AW    registered line index to the register bank
//  rd_data     in   DW    data_out_bus from the register bank
//  out_valid   out  1     FIFO head valid
//  out_ready   in   1     consumer accepts head when out_valid&&out_ready
//  out_data    out  DW    word read from the bank
//  out_line    out  AW    line index of out_data
//  out_last    out  1     head is the final word of the burst
// BEHAVIOUR
//  Reset (async): every output goes to 0; FIFO empty; in-flight pipe cleared; FSM=IDLE.
//   Any burst in progress is abandoned and nothing is emitted after reset.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE:  start=1 and count!=0 -> latch start_line/count, busy=1, go to ISSUE.
//          start=1 and count==0 -> done pulses next cycle; busy stays 0.
//   ISSUE: one read per cycle while credit is available.
//          credit = fifo_count + inflight < DEPTH.
//          Each issue: read_en=1, read_line=cur, cur=cur+1 mod 16 (15 wraps to 0).
//          Last read issued -> DRAIN.
//   DRAIN: read_en=0. Wait until inflight==0, the FIFO is empty and the last word is popped.
//          Then done=1 for one cycle, busy=0, go to IDLE.
//  start while busy is ignored; there is no queuing.
//  Read timing:
//   - The bank samples read_en=1 at edge E.
//   - The block captures rd_data at edge E+RD_LAT, tagged with that read's line.
//   - Tags travel through an RD_LAT-deep in-flight shift pipe.
//  read_en is never high in two cycles for the same line within a burst.
//  Consecutive issues are back-to-back when credit allows.
//  Credit rules:
//   - A pop frees a slot the same cycle; a capture consumes one.
//   - Capture and pop in the same cycle leave fifo_count unchanged.
//   - The FIFO never overflows; any overflow is a design error.
//  out_last is set only on the entry holding the count-th word.
//  Output ordering is strictly the line order from start_line upward, with wrap.
//  Throughput: 1 word/cycle sustained when out_ready stays 1.
//  Latency: start edge -> first out_valid is 1+1+RD_LAT cycles.
//  out_data/out_line/out_last hold stable while out_valid=1 and out_ready=0.
// TESTING
//  T1 Reset/idle:
//     reset_n=0 mid-burst -> all outputs 0 immediately.
//     After release, no read_en or out_valid until a new start.
//  T2 Basic burst:
//     Preload lines 0..15 with 32'hA000_0000+i; start_line=2, count=3, out_ready=1.
//     -> out_data A0000002,3,4; out_line 2,3,4; out_last only on 4.
//     -> done 1 cycle after the last pop.
//  T3 Wrap:
//     start_line=14, count=4 -> lines 14,15,0,1 in order.
//  T4 Back-pressure:
//     count=16, out_ready=0 for 20 cycles.
//     -> exactly DEPTH reads issued, no overflow, head held stable.
//     Release ready -> all 16 words delivered in order.
//  T5 Empty burst, start while busy:
//     count=0 -> done pulse, no read_en, busy never 1.
//     start during a burst -> ignored; word count unchanged.
//  T6 RD_LAT=3 build:
//     Repeat T2/T4 -> identical output stream and no overflow.

Source files
------------

// File: rtl/regfile_burst_reader.sv
// Read-side sequencer for the 16x32 register bank: issues a contiguous run of line
// reads, tags returning words with their line index and streams them through a small FIFO.
module regfile_burst_reader #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_line,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          read_en,
    output logic [AW-1:0] read_line,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_line,
    output logic          out_last
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] cur_line;
    logic [AW:0]   remaining;
    logic          read_last;
    logic          empty_pulse;
    logic [CW-1:0] inflight;

    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_last;
    logic [AW-1:0]     pipe_line [RD_LAT];

    logic [DW-1:0]    fifo_data [DEPTH];
    logic [AW-1:0]    fifo_line [DEPTH];
    logic [DEPTH-1:0] fifo_last;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;

    logic          push;
    logic          pop;
    logic          accept;
    logic          issue;
    logic          credit;
    logic          drain_done;
    logic [CW:0]   occupancy;

    // Occupancy counts every slot already promised: FIFO entries plus reads not yet
    // captured, less the entry leaving this cycle, so a new read never overflows the FIFO.
    always_comb begin
        push       = pipe_valid[RD_LAT-1];
        pop        = (fifo_count != '0) && out_ready;
        accept     = (state == IDLE) && start && (count != '0);
        occupancy  = {1'b0, fifo_count} + {1'b0, inflight} - {{CW{1'b0}}, pop};
        credit     = occupancy < (CW+1)'(DEPTH);
        issue      = (state == ISSUE) && credit;
        drain_done = (state == DRAIN) && (inflight == '0) && (fifo_count == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && (remaining == (AW+1)'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ISSUE) || ((state == DRAIN) && !drain_done);
        done = empty_pulse || drain_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_line    <= '0;
            remaining   <= '0;
            read_en     <= 1'b0;
            read_line   <= '0;
            read_last   <= 1'b0;
            empty_pulse <= 1'b0;
        end else begin
            empty_pulse <= (state == IDLE) && start && (count == '0);
            read_en     <= issue;
            if (accept) begin
                cur_line  <= start_line;
                remaining <= count;
            end
            if (issue) begin
                read_line <= cur_line;
                read_last <= (remaining == (AW+1)'(1));
                cur_line  <= cur_line + AW'(1);
                remaining <= remaining - (AW+1)'(1);
            end
        end
    end

    // Reads leave the count when their word is captured into the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tag pipe mirrors the bank latency so each tag meets its word at capture time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_line[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= read_en;
            pipe_last[0]  <= read_en && read_last;
            pipe_line[0]  <= read_line;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_last[k]  <= pipe_last[k-1];
                pipe_line[k]  <= pipe_line[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                fifo_data[k] <= '0;
                fifo_line[k] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_line[wr_ptr] <= pipe_line[RD_LAT-1];
                fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        out_valid = (fifo_count != '0);
        out_data  = out_valid ? fifo_data[rd_ptr] : '0;
        out_line  = out_valid ? fifo_line[rd_ptr] : '0;
        out_last  = out_valid && fifo_last[rd_ptr];
    end

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Drives an RD_LAT=1 and an RD_LAT=3 instance with identical commands and checks both
// output streams against a line-order reference model of the register bank.
module tb_regfile_burst_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  start_line;
    logic [4:0]  count;
    logic        out_ready;

    logic        busy_w      [2];
    logic        done_w      [2];
    logic        read_en_w   [2];
    logic [3:0]  read_line_w [2];
    logic [31:0] rd_data_w   [2];
    logic        out_valid_w [2];
    logic [31:0] out_data_w  [2];
    logic [3:0]  out_line_w  [2];
    logic        out_last_w  [2];

    logic [31:0] mem [16];
    int          lat_of [2] = '{1, 3};

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int start_cyc;

    logic [36:0] got [2][64];
    int          got_n [2];
    int          reads [2];
    int          dones [2];
    int          done_cyc [2];
    int          last_pop_cyc [2];
    int          first_valid_cyc [2];
    bit          seen_valid [2];
    bit          busy_seen [2];
    int          hold_err [2];
    bit          prev_hold [2];
    logic [36:0] prev_word [2];
    logic [36:0] mon_word;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Each instance gets its own bank model with the matching read latency.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] stage [LAT];

        always @(posedge clk) begin
            stage[0] <= read_en_w[g] ? mem[read_line_w[g]] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
        end
        assign rd_data_w[g] = stage[LAT-1];

        regfile_burst_reader #(.DW(32), .AW(4), .RD_LAT(LAT), .DEPTH(4)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start),
            .start_line (start_line),
            .count      (count),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .read_en    (read_en_w[g]),
            .read_line  (read_line_w[g]),
            .rd_data    (rd_data_w[g]),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready),
            .out_data   (out_data_w[g]),
            .out_line   (out_line_w[g]),
            .out_last   (out_last_w[g])
        );
    end

    // Monitor samples on the falling edge, away from where the DUT updates.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                prev_hold[k] = 1'b0;
            end else begin
                mon_word = {out_data_w[k], out_line_w[k], out_last_w[k]};
                if (prev_hold[k] && (!out_valid_w[k] || mon_word != prev_word[k])) hold_err[k]++;
                if (out_valid_w[k] && !seen_valid[k]) begin
                    seen_valid[k]      = 1'b1;
                    first_valid_cyc[k] = cyc;
                end
                if (out_valid_w[k] && out_ready) begin
                    if (got_n[k] < 64) got[k][got_n[k]] = mon_word;
                    got_n[k]++;
                    last_pop_cyc[k] = cyc;
                end
                prev_hold[k] = out_valid_w[k] && !out_ready;
                prev_word[k] = mon_word;
                if (read_en_w[k]) reads[k]++;
                if (done_w[k]) begin
                    dones[k]++;
                    done_cyc[k] = cyc;
                end
                if (busy_w[k]) busy_seen[k] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        else
            passes++;
    endtask

    task automatic clearMon();
        for (int k = 0; k < 2; k++) begin
            got_n[k]        = 0;
            reads[k]        = 0;
            dones[k]        = 0;
            done_cyc[k]     = -100;
            last_pop_cyc[k] = -100;
            seen_valid[k]   = 1'b0;
            busy_seen[k]    = 1'b0;
            hold_err[k]     = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sl, input int cnt);
        tick(1);
        start      = 1'b1;
        start_line = 4'(sl);
        count      = 5'(cnt);
        start_cyc  = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit rnd_ready);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (dones[0] > 0 && dones[1] > 0) break;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        tick(2);
    endtask

    // Reference: word i of a burst is line (sl+i) mod 16, flagged last only at i == cnt-1.
    function automatic logic [36:0] expWord(input int sl, input int i, input int cnt);
        logic [3:0] line;
        line = 4'((sl + i) % 16);
        return {mem[line], line, (i == cnt - 1)};
    endfunction

    task automatic checkBurst(input string tag, input int sl, input int cnt);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_L%0d_words", tag, lat_of[k]), 64'(got_n[k]), 64'(cnt));
            for (int i = 0; i < cnt && i < got_n[k] && i < 64; i++)
                checkOutput($sformatf("%s_L%0d_w%0d", tag, lat_of[k], i), 64'(got[k][i]), 64'(expWord(sl, i, cnt)));
            checkOutput($sformatf("%s_L%0d_done", tag, lat_of[k]), 64'(dones[k]), 64'd1);
            checkOutput($sformatf("%s_L%0d_done_gap", tag, lat_of[k]), 64'(done_cyc[k] - last_pop_cyc[k]), 64'd1);
            checkOutput($sformatf("%s_L%0d_hold", tag, lat_of[k]), 64'(hold_err[k]), 64'd0);
        end
    endtask

    task automatic checkQuiet(input string tag);
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("%s_L%0d", tag, lat_of[k]),
                        {19'd0, busy_w[k], done_w[k], read_en_w[k], read_line_w[k], out_valid_w[k],
                         out_data_w[k], out_line_w[k], out_last_w[k]}, 64'd0);
    endtask

    initial begin
        int sl;
        int cnt;
        reset_n    = 1'b0;
        start      = 1'b0;
        start_line = '0;
        count      = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
        clearMon();
        tick(3);
        checkQuiet("reset_state");
        reset_n = 1'b1;

        // Basic burst with latency check
        clearMon();
        out_ready = 1'b1;
        applyStimulus(2, 3);
        waitDone(200, 1'b0);
        checkBurst("basic", 2, 3);
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("latency_L%0d", lat_of[k]), 64'(first_valid_cyc[k] - start_cyc), 64'(3 + lat_of[k]));

        // Wrap past line 15
        clearMon();
        applyStimulus(14, 4);
        waitDone(200, 1'b0);
        checkBurst("wrap", 14, 4);

        // Back-pressure: consumer stalls, reads stop at FIFO depth
        clearMon();
        out_ready = 1'b0;
        applyStimulus(0, 16);
        tick(20);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("bp_reads_L%0d", lat_of[k]), 64'(reads[k]), 64'd4);
            checkOutput($sformatf("bp_valid_L%0d", lat_of[k]), 64'(out_valid_w[k]), 64'd1);
        end
        out_ready = 1'b1;
        waitDone(300, 1'b0);
        checkBurst("backpressure", 0, 16);

        // Empty burst
        clearMon();
        applyStimulus(7, 0);
        tick(4);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("empty_done_L%0d", lat_of[k]), 64'(dones[k]), 64'd1);
            checkOutput($sformatf("empty_reads_L%0d", lat_of[k]), 64'(reads[k]), 64'd0);
            checkOutput($sformatf("empty_busy_L%0d", lat_of[k]), 64'(busy_seen[k]), 64'd0);
        end

        // Start while busy is ignored
        clearMon();
        applyStimulus(5, 8);
        tick(2);
        checkOutput("busy_mid", {62'd0, busy_w[0], busy_w[1]}, 64'd3);
        applyStimulus(0, 5);
        waitDone(300, 1'b0);
        checkBurst("ignore_start", 5, 8);

        // Randomized bursts with random memory and random back-pressure
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            sl  = $urandom_range(0, 15);
            cnt = $urandom_range(1, 16);
            clearMon();
            out_ready = 1'b1;
            applyStimulus(sl, cnt);
            waitDone(600, 1'b1);
            checkBurst($sformatf("rand%0d", b), sl, cnt);
        end

        // Reset mid-burst abandons everything
        clearMon();
        out_ready = 1'b0;
        applyStimulus(3, 16);
        tick(6);
        reset_n = 1'b0;
        #1;
        checkQuiet("reset_mid_burst");
        tick(2);
        reset_n = 1'b1;
        clearMon();
        out_ready = 1'b1;
        tick(15);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("post_reset_reads_L%0d", lat_of[k]), 64'(reads[k]), 64'd0);
            checkOutput($sformatf("post_reset_words_L%0d", lat_of[k]), 64'(got_n[k]), 64'd0);
            checkOutput($sformatf("post_reset_valid_L%0d", lat_of[k]), 64'(seen_valid[k]), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
